hazard_ctrl: RTL and testbench

Pipeline hazard and multi-cycle sequencing controller for the five-stage core. Generates forwarding selects for the Execute-stage operands. Produces the enable/clear controls for the Fetch, Decode/Execute and Execute/Memory pipeline registers to resolve load-use and branch hazards. Runs a small FSM that holds the pipeline while the multi-cycle multiply/divide unit (MCycle) works, with a timeout watchdog.

---
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-unit bundle: register addresses, write qualifiers and
// multi-cycle handshake in, forwarding selects and pipeline enables/clears out.
interface hazard_ctrl_if;
  logic [3:0] RA1D, RA2D;
  logic [3:0] RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W;
  logic       RegWE, RegWM, RegWW;
  logic       MemtoRegE;
  logic       PCSrcE;
  logic       MCycleOpE, CondExE;
  logic       MCDone;

  logic [1:0] ForwardAE, ForwardBE;
  logic       EnF, EnD, EnE;
  logic       ClrD, ClrE, ClrM;
  logic       MCStart;
  logic       MCResultSel;
  logic       MCAbort;
  logic       MCError;

  // Pipeline datapath side
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWE, RegWM, RegWW, MemtoRegE, PCSrcE,
           MCycleOpE, CondExE, MCDone,
    input  ForwardAE, ForwardBE, EnF, EnD, EnE, ClrD, ClrE, ClrM,
           MCStart, MCResultSel, MCAbort, MCError
  );

  // Hazard controller side
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWE, RegWM, RegWW, MemtoRegE, PCSrcE,
           MCycleOpE, CondExE, MCDone,
    output ForwardAE, ForwardBE, EnF, EnD, EnE, ClrD, ClrE, ClrM,
           MCStart, MCResultSel, MCAbort, MCError
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: operand forwarding, load-use and
// branch stall/flush, and the IDLE/BUSY/DONE sequencer for the MCycle unit.
module hazard_ctrl #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        Reset,
  hazard_ctrl_if.slave hz
);

  localparam int CW = $clog2(MC_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            error_q, error_d;
  logic            ld_stall;
  logic            mc_req;

  // R15 reads come from the datapath's PC path, never from a bypass.
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic       regwm,
    input logic [3:0] wa3m,
    input logic       regww,
    input logic [3:0] wa3w
  );
    if (ra == 4'd15)                 return 2'b00;
    else if (regwm && (wa3m == ra))  return 2'b10;
    else if (regww && (wa3w == ra))  return 2'b01;
    else                             return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.RA1E, hz.RegWM, hz.WA3M, hz.RegWW, hz.WA3W);
  assign hz.ForwardBE = fwd_sel(hz.RA2E, hz.RegWM, hz.WA3M, hz.RegWW, hz.WA3W);

  assign ld_stall = hz.MemtoRegE && hz.RegWE &&
                    ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
  assign mc_req   = hz.MCycleOpE && hz.CondExE;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d        = state_q;
    count_d        = count_q;
    error_d        = error_q;
    hz.EnF         = 1'b1;
    hz.EnD         = 1'b1;
    hz.EnE         = 1'b1;
    hz.ClrD        = 1'b0;
    hz.ClrE        = 1'b0;
    hz.ClrM        = 1'b0;
    hz.MCStart     = 1'b0;
    hz.MCResultSel = 1'b0;
    hz.MCAbort     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mc_req) begin
          hz.MCStart = 1'b1;
          hz.EnF     = 1'b0;
          hz.EnD     = 1'b0;
          hz.EnE     = 1'b0;
          hz.ClrM    = 1'b1;
          count_d    = '0;
          state_d    = BUSY;
        end else if (hz.PCSrcE) begin
          hz.ClrD = 1'b1;
          hz.ClrE = 1'b1;
        end else if (ld_stall) begin
          hz.EnF  = 1'b0;
          hz.EnD  = 1'b0;
          hz.ClrE = 1'b1;
        end
      end

      BUSY: begin
        hz.EnF  = 1'b0;
        hz.EnD  = 1'b0;
        hz.EnE  = 1'b0;
        hz.ClrM = 1'b1;
        count_d = count_q + 1'b1;
        // A result arriving on the last allowed cycle still counts as success.
        if (hz.MCDone) begin
          state_d = DONE;
        end else if (count_q == CW'(MC_TIMEOUT - 1)) begin
          hz.MCAbort = 1'b1;
          error_d    = 1'b1;
          hz.ClrE    = 1'b1;
          hz.EnF     = 1'b1;
          hz.EnD     = 1'b1;
          hz.EnE     = 1'b1;
          state_d    = IDLE;
        end
      end

      DONE: begin
        hz.MCResultSel = 1'b1;
        state_d        = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign hz.MCError = error_q;

  // NOTE: reset is asynchronous so a reset mid-operation drops to IDLE without waiting for a clock edge.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int TMO = 8;

  typedef struct packed {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic       regwe, regwm, regww, memtoreg, pcsrc, mcop, condex, mcdone;
  } in_t;

  // {ForwardAE, ForwardBE, EnF/EnD/EnE, ClrD/ClrE/ClrM, MCStart/MCResultSel/MCAbort/MCError}
  typedef struct packed {
    in_t         in;
    logic [13:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MC_TIMEOUT(TMO)) dut (
    .CLK   (clk),
    .Reset (rst),
    .hz    (hif.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: whether an MC op is in flight, how many busy
  // cycles it has consumed, whether the result cycle is next, sticky error.
  bit m_busy;
  bit m_done_next;
  int m_busy_cyc;
  bit m_err;

  function automatic logic [13:0] o(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic [2:0] en, input logic [2:0] clr,
                                    input logic [3:0] mc);
    return {fa, fb, en, clr, mc};
  endfunction

  function automatic logic [13:0] outs();
    return {hif.ForwardAE, hif.ForwardBE, hif.EnF, hif.EnD, hif.EnE,
            hif.ClrD, hif.ClrE, hif.ClrM,
            hif.MCStart, hif.MCResultSel, hif.MCAbort, hif.MCError};
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
  endtask

  task automatic apply(input in_t v);
    hif.RA1D = v.ra1d;  hif.RA2D = v.ra2d;
    hif.RA1E = v.ra1e;  hif.RA2E = v.ra2e;
    hif.WA3E = v.wa3e;  hif.WA3M = v.wa3m;  hif.WA3W = v.wa3w;
    hif.RegWE = v.regwe; hif.RegWM = v.regwm; hif.RegWW = v.regww;
    hif.MemtoRegE = v.memtoreg;
    hif.PCSrcE    = v.pcsrc;
    hif.MCycleOpE = v.mcop;
    hif.CondExE   = v.condex;
    hif.MCDone    = v.mcdone;
  endtask

  task automatic step(input string name, input in_t v, input logic [13:0] e);
    @(negedge clk);
    apply(v);
    #1;
    check(name, outs(), e);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [3:0] ra, input in_t v);
    if (ra == 4'd15) return 2'b00;
    if (v.regwm && v.wa3m == ra) return 2'b10;
    if (v.regww && v.wa3w == ra) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for this cycle, then advance the model past the clock edge.
  task automatic model_step(input in_t v, output logic [13:0] e);
    logic [2:0] en, clr;
    logic st, rs, ab;
    en = 3'b111; clr = 3'b000; st = 1'b0; rs = 1'b0; ab = 1'b0;
    if (m_done_next) begin
      rs = 1'b1;
      m_done_next = 1'b0;
    end else if (m_busy) begin
      m_busy_cyc++;
      en  = 3'b000;
      clr = 3'b001;
      if (v.mcdone) begin
        m_busy = 1'b0;
        m_done_next = 1'b1;
      end else if (m_busy_cyc == TMO) begin
        ab = 1'b1; en = 3'b111; clr = 3'b011;
        m_busy = 1'b0;
      end
    end else if (v.mcop && v.condex) begin
      st = 1'b1; en = 3'b000; clr = 3'b001;
      m_busy = 1'b1;
      m_busy_cyc = 0;
    end else if (v.pcsrc) begin
      clr = 3'b110;
    end else if (v.memtoreg && v.regwe && (v.wa3e == v.ra1d || v.wa3e == v.ra2d)) begin
      en = 3'b001; clr = 3'b010;
    end
    e = {ref_fwd(v.ra1e, v), ref_fwd(v.ra2e, v), en, clr, st, rs, ab, m_err};
    if (ab) m_err = 1'b1;
  endtask

  function automatic logic [3:0] rnd_reg();
    case ($urandom_range(0, 4))
      0:       return 4'd1;
      1:       return 4'd2;
      2:       return 4'd3;
      3:       return 4'd15;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  localparam logic [13:0] RUN  = 14'b00_00_111_000_0000;
  localparam logic [13:0] RUNE = 14'b00_00_111_000_0001;

  initial begin
    vec_t        tbl[$];
    in_t         zero, mc, v;
    logic [13:0] e;

    zero = '0;
    mc   = '0;
    mc.mcop   = 1'b1;
    mc.condex = 1'b1;

    rst = 1'b1;
    apply(zero);
    #3;
    check("reset_state", outs(), RUN);
    @(negedge clk);
    rst = 1'b0;

    // Combinational vectors, FSM stays in IDLE throughout.
    tbl.push_back('{in: '{regwm:1, regww:1, wa3m:5, wa3w:5, ra1e:5, default:0}, exp: o(2'b10, 2'b00, 3'b111, 3'b000, 4'b0000)});
    tbl.push_back('{in: '{regwm:0, regww:1, wa3m:5, wa3w:5, ra1e:5, default:0}, exp: o(2'b01, 2'b00, 3'b111, 3'b000, 4'b0000)});
    tbl.push_back('{in: '{regwm:1, regww:1, wa3m:15, wa3w:15, ra1e:15, default:0}, exp: RUN});
    tbl.push_back('{in: '{regwm:1, wa3m:7, ra2e:7, default:0}, exp: o(2'b00, 2'b10, 3'b111, 3'b000, 4'b0000)});
    tbl.push_back('{in: '{regww:1, wa3w:2, ra1e:2, ra2e:2, default:0}, exp: o(2'b01, 2'b01, 3'b111, 3'b000, 4'b0000)});
    tbl.push_back('{in: '{regwm:1, wa3m:4, ra1e:5, default:0}, exp: RUN});
    tbl.push_back('{in: '{regww:0, wa3w:5, ra1e:5, default:0}, exp: RUN});
    tbl.push_back('{in: '{regwm:1, regww:1, wa3m:6, wa3w:9, ra1e:9, ra2e:6, default:0}, exp: o(2'b01, 2'b10, 3'b111, 3'b000, 4'b0000)});
    tbl.push_back('{in: '{memtoreg:1, regwe:1, wa3e:3, ra2d:3, default:0}, exp: o(2'b00, 2'b00, 3'b001, 3'b010, 4'b0000)});
    tbl.push_back('{in: '{regwm:1, wa3m:3, ra2e:3, default:0}, exp: o(2'b00, 2'b10, 3'b111, 3'b000, 4'b0000)});
    tbl.push_back('{in: '{memtoreg:1, regwe:1, wa3e:9, ra1d:9, default:0}, exp: o(2'b00, 2'b00, 3'b001, 3'b010, 4'b0000)});
    tbl.push_back('{in: '{memtoreg:1, regwe:1, wa3e:3, ra1d:4, ra2d:5, default:0}, exp: RUN});
    tbl.push_back('{in: '{memtoreg:1, regwe:0, wa3e:3, ra2d:3, default:0}, exp: RUN});
    tbl.push_back('{in: '{memtoreg:0, regwe:1, wa3e:3, ra2d:3, default:0}, exp: RUN});
    tbl.push_back('{in: '{pcsrc:1, default:0}, exp: o(2'b00, 2'b00, 3'b111, 3'b110, 4'b0000)});
    tbl.push_back('{in: '{pcsrc:1, memtoreg:1, regwe:1, wa3e:3, ra2d:3, default:0}, exp: o(2'b00, 2'b00, 3'b111, 3'b110, 4'b0000)});
    tbl.push_back('{in: '{mcop:1, condex:0, default:0}, exp: RUN});
    tbl.push_back('{in: '{mcdone:1, default:0}, exp: RUN});

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);

    // MC op with MCDone four cycles after start.
    step("mc_start", mc, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b1000));
    for (int i = 1; i <= 4; i++) begin
      v = mc;
      v.mcdone = (i == 4);
      step($sformatf("mc_busy%0d", i), v, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b0000));
    end
    step("mc_done", mc, o(2'b00, 2'b00, 3'b111, 3'b000, 4'b0100));
    step("mc_idle", zero, RUN);

    // Timeout: MCDone never arrives.
    step("to_start", mc, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b1000));
    for (int i = 1; i < TMO; i++)
      step($sformatf("to_busy%0d", i), mc, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b0000));
    step("to_abort", mc, o(2'b00, 2'b00, 3'b111, 3'b011, 4'b0010));
    step("to_err_sticky", zero, RUNE);
    v = zero;
    v.mcdone = 1'b1;
    step("to_stray_done", v, RUNE);

    // Follow-up op completes normally, error stays set.
    step("op2_start", mc, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b1001));
    v = mc;
    v.mcdone = 1'b1;
    step("op2_busy", v, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b0001));
    step("op2_done", mc, o(2'b00, 2'b00, 3'b111, 3'b000, 4'b0101));
    step("op2_idle", zero, RUNE);

    // Done on the last allowed busy cycle beats the timeout.
    step("tie_start", mc, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b1001));
    for (int i = 1; i <= TMO; i++) begin
      v = mc;
      v.mcdone = (i == TMO);
      step($sformatf("tie_busy%0d", i), v, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b0001));
    end
    step("tie_done", mc, o(2'b00, 2'b00, 3'b111, 3'b000, 4'b0101));

    // Reset during busy cycle 3, then a late MCDone.
    step("rst_start", mc, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b1001));
    for (int i = 1; i <= 3; i++)
      step($sformatf("rst_busy%0d", i), mc, o(2'b00, 2'b00, 3'b000, 3'b001, 4'b0001));
    #1;
    apply(zero);
    rst = 1'b1;
    #1;
    check("rst_async", outs(), RUN);
    @(negedge clk);
    rst = 1'b0;
    v = zero;
    v.mcdone = 1'b1;
    step("rst_late_done", v, RUN);
    step("rst_idle", zero, RUN);

    // Random traffic against the reference model.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_busy = 1'b0; m_done_next = 1'b0; m_busy_cyc = 0; m_err = 1'b0;
    for (int c = 0; c < 800; c++) begin
      v.ra1d = rnd_reg(); v.ra2d = rnd_reg();
      v.ra1e = rnd_reg(); v.ra2e = rnd_reg();
      v.wa3e = rnd_reg(); v.wa3m = rnd_reg(); v.wa3w = rnd_reg();
      v.regwe    = 1'($urandom_range(0, 1));
      v.regwm    = 1'($urandom_range(0, 1));
      v.regww    = 1'($urandom_range(0, 1));
      v.memtoreg = ($urandom_range(0, 2) == 0);
      v.pcsrc    = ($urandom_range(0, 5) == 0);
      v.mcop     = ($urandom_range(0, 4) == 0);
      v.condex   = ($urandom_range(0, 3) != 0);
      v.mcdone   = ($urandom_range(0, 5) == 0);
      model_step(v, e);
      step($sformatf("rand%0d", c), v, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
